// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush/enable sequencing for load-use, taken
// branches and data-memory wait states, plus EX-stage operand forwarding selects.
module hazard_unit #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        MemReadE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        EnF,
  output logic        EnD,
  output logic        EnE,
  output logic        EnM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        BusErr,
  output logic [31:0] StallCnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(WAIT_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             bus_err_nxt;
  logic             load_use, mem_wait;
  logic             freeze, run_mode;

  assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = MemReqM && !MemReadyM;

  // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    bus_err_nxt  = BusErr;
    freeze       = 1'b0;
    run_mode     = 1'b0;
    EnF          = 1'b0;
    EnD          = 1'b0;
    EnE          = 1'b0;
    EnM          = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    ForwardAE    = 2'b00;
    ForwardBE    = 2'b00;

    case (state)
      RUN: begin
        if (mem_wait) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else begin
          run_mode = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if ((WAIT_TIMEOUT != 0) && (wait_cnt == TIMEOUT)) begin
            bus_err_nxt = 1'b1;
            state_nxt   = ERR;
          end
        end else begin
          // Release cycle: the held instructions move on under normal priorities.
          run_mode     = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      ERR:     freeze    = 1'b1;
      default: state_nxt = RUN;
    endcase

    // A frozen pipeline only bubbles WB; branch/load flushes wait until release.
    if (freeze) begin
      FlushW = 1'b1;
    end else if (run_mode) begin
      if (PCSrcE) begin
        {EnF, EnD, EnE, EnM} = 4'b1111;
        FlushD               = 1'b1;
        FlushE               = 1'b1;
      end else if (load_use) begin
        {EnE, EnM} = 2'b11;
        FlushE     = 1'b1;
      end else begin
        {EnF, EnD, EnE, EnM} = 4'b1111;
      end
    end

    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;

    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

    if (!rst) begin
      {EnF, EnD, EnE, EnM}    = 4'b0000;
      {FlushD, FlushE, FlushW} = 3'b000;
      ForwardAE               = 2'b00;
      ForwardBE               = 2'b00;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      BusErr   <= 1'b0;
      StallCnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      BusErr   <= bus_err_nxt;
      if (!EnF && (StallCnt != 32'hFFFF_FFFF)) StallCnt <= StallCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a cycle-level behavioural model.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic       memreade, pcsrce;
    logic [4:0] rdm, rdw;
    logic       regwritem, regwritew, memreqm, memreadym;
  } in_t;

  typedef struct packed {
    logic [3:0] en;     // {EnF, EnD, EnE, EnM}
    logic [2:0] flush;  // {FlushD, FlushE, FlushW}
    logic [1:0] fa, fb;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rst_to;
  always #5 clk = ~clk;

  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic        EnF, EnD, EnE, EnM, FlushD, FlushE, FlushW, BusErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCnt;
  logic        to_EnF, to_EnD, to_EnE, to_EnM, to_FlushD, to_FlushE, to_FlushW, to_BusErr;
  logic [1:0]  to_ForwardAE, to_ForwardBE;
  logic [31:0] to_StallCnt;

  hazard_unit u_dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .EnF(EnF), .EnD(EnD),
    .EnE(EnE), .EnM(EnM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BusErr(BusErr), .StallCnt(StallCnt)
  );

  hazard_unit #(.WAIT_TIMEOUT(3), .CNT_W(8)) u_to (
    .clk(clk), .rst(rst_to), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .EnF(to_EnF), .EnD(to_EnD),
    .EnE(to_EnE), .EnM(to_EnM), .FlushD(to_FlushD), .FlushE(to_FlushE), .FlushW(to_FlushW),
    .ForwardAE(to_ForwardAE), .ForwardBE(to_ForwardBE), .BusErr(to_BusErr), .StallCnt(to_StallCnt)
  );

  int checks = 0;
  int failures = 0;

  // Model state for u_dut (timeout 255): error flag, consecutive wait cycles so far, stall total.
  localparam int MAIN_TIMEOUT = 255;
  bit          m_err;
  int          m_waits;
  logic [31:0] m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    Rs1D = i.rs1d; Rs2D = i.rs2d; Rs1E = i.rs1e; Rs2E = i.rs2e; RdE = i.rde;
    MemReadE = i.memreade; PCSrcE = i.pcsrce; RdM = i.rdm; RdW = i.rdw;
    RegWriteM = i.regwritem; RegWriteW = i.regwritew; MemReqM = i.memreqm; MemReadyM = i.memreadym;
  endtask

  function automatic logic [1:0] fwd(input in_t i, input logic [4:0] rs);
    if (i.regwritem && i.rdm != 0 && i.rdm == rs) return 2'b10;
    if (i.regwritew && i.rdw != 0 && i.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input in_t i);
    out_t o;
    bit   lu, mw;
    lu = i.memreade && i.rde != 0 && (i.rde == i.rs1d || i.rde == i.rs2d);
    mw = i.memreqm && !i.memreadym;
    o.fa = fwd(i, i.rs1e);
    o.fb = fwd(i, i.rs2e);
    if (m_err || mw)   begin o.en = 4'b0000; o.flush = 3'b001; end
    else if (i.pcsrce) begin o.en = 4'b1111; o.flush = 3'b110; end
    else if (lu)       begin o.en = 4'b0011; o.flush = 3'b010; end
    else               begin o.en = 4'b1111; o.flush = 3'b000; end
    return o;
  endfunction

  task automatic model_update(input in_t i);
    out_t o;
    bit   mw;
    o  = model_out(i);
    mw = i.memreqm && !i.memreadym;
    if (!o.en[3] && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (!m_err) begin
      if (mw) begin
        // Error when a further wait cycle arrives after MAIN_TIMEOUT waits already elapsed.
        if (m_waits == MAIN_TIMEOUT) m_err = 1'b1;
        m_waits++;
      end else begin
        m_waits = 0;
      end
    end
  endtask

  // Entered and left just after a rising edge; outputs compared on the falling edge.
  task automatic run_cycle(input in_t i, input out_t exp, input string name);
    drive(i);
    @(negedge clk);
    check({name, " en"},       {EnF, EnD, EnE, EnM},    exp.en);
    check({name, " flush"},    {FlushD, FlushE, FlushW}, exp.flush);
    check({name, " fwdA"},     ForwardAE,               exp.fa);
    check({name, " fwdB"},     ForwardBE,               exp.fb);
    check({name, " buserr"},   BusErr,                  m_err);
    check({name, " stallcnt"}, StallCnt,                m_stall);
    @(posedge clk);
    model_update(i);
    #1;
  endtask

  task automatic model_cycle(input in_t i, input string name);
    run_cycle(i, model_out(i), name);
  endtask

  task automatic do_reset();
    in_t f;
    f = '0;
    f.regwritem = 1'b1; f.rdm = 5'd3; f.rs1e = 5'd3; f.rs2e = 5'd3;
    drive(f);
    rst = 1'b0;
    #1;
    check("reset en",       {EnF, EnD, EnE, EnM},     4'b0000);
    check("reset flush",    {FlushD, FlushE, FlushW}, 3'b000);
    check("reset fwd",      {ForwardAE, ForwardBE},   4'b0000);
    check("reset buserr",   BusErr,                   1'b0);
    check("reset stallcnt", StallCnt,                 32'd0);
    m_err = 1'b0; m_waits = 0; m_stall = '0;
    @(negedge clk);
    drive('0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[13];
  in_t  w, wr, c;

  initial begin
    rst = 1'b0; rst_to = 1'b0;
    drive('0);
    @(posedge clk); #1;
    do_reset();

    // Fields: rs1d rs2d rs1e rs2e rde memreade pcsrce rdm rdw regwritem regwritew memreqm memreadym
    vt[0]  = '{"idle",         '{0,0,0,0,0, 0,0, 0,0, 0,0, 0,0}, '{4'b1111, 3'b000, 2'b00, 2'b00}};
    vt[1]  = '{"loaduse rs1",  '{5,0,0,0,5, 1,0, 0,0, 0,0, 0,0}, '{4'b0011, 3'b010, 2'b00, 2'b00}};
    vt[2]  = '{"loaduse rs2",  '{1,7,0,0,7, 1,0, 0,0, 0,0, 0,0}, '{4'b0011, 3'b010, 2'b00, 2'b00}};
    vt[3]  = '{"load to x0",   '{0,0,0,0,0, 1,0, 0,0, 0,0, 0,0}, '{4'b1111, 3'b000, 2'b00, 2'b00}};
    vt[4]  = '{"no load",      '{5,0,0,0,5, 0,0, 0,0, 0,0, 0,0}, '{4'b1111, 3'b000, 2'b00, 2'b00}};
    vt[5]  = '{"branch+lu",    '{5,0,0,0,5, 1,1, 0,0, 0,0, 0,0}, '{4'b1111, 3'b110, 2'b00, 2'b00}};
    vt[6]  = '{"fwdA mem",     '{0,0,3,0,0, 0,0, 3,3, 1,1, 0,0}, '{4'b1111, 3'b000, 2'b10, 2'b00}};
    vt[7]  = '{"fwdA rdm0",    '{0,0,3,0,0, 0,0, 0,3, 1,1, 0,0}, '{4'b1111, 3'b000, 2'b01, 2'b00}};
    vt[8]  = '{"fwdB wb",      '{0,0,0,9,0, 0,0, 9,9, 0,1, 0,0}, '{4'b1111, 3'b000, 2'b00, 2'b01}};
    vt[9]  = '{"fwd both",     '{0,0,4,6,0, 0,0, 4,6, 1,1, 0,0}, '{4'b1111, 3'b000, 2'b10, 2'b01}};
    vt[10] = '{"fwd wb off",   '{0,0,3,0,0, 0,0, 0,3, 0,0, 0,0}, '{4'b1111, 3'b000, 2'b00, 2'b00}};
    vt[11] = '{"memwait prio", '{5,0,0,0,5, 1,1, 0,0, 0,0, 1,0}, '{4'b0000, 3'b001, 2'b00, 2'b00}};
    vt[12] = '{"release",      '{0,0,0,0,0, 0,0, 0,0, 0,0, 1,1}, '{4'b1111, 3'b000, 2'b00, 2'b00}};
    for (int k = 0; k < 13; k++) run_cycle(vt[k].in, vt[k].exp, vt[k].name);

    // lw x5 followed by a dependent instruction: one stall, then forward from WB.
    c = '0; c.memreade = 1; c.rde = 5; c.rs1d = 5;
    run_cycle(c, '{4'b0011, 3'b010, 2'b00, 2'b00}, "lw stall");
    c = '0; c.rs1d = 5; c.rdm = 5; c.regwritem = 1; c.memreqm = 1; c.memreadym = 1;
    run_cycle(c, '{4'b1111, 3'b000, 2'b00, 2'b00}, "lw bubble");
    c = '0; c.rs1e = 5; c.rdw = 5; c.regwritew = 1;
    run_cycle(c, '{4'b1111, 3'b000, 2'b01, 2'b00}, "lw fwd wb");

    // Four frozen cycles with a taken branch held in EX, flushed only on release.
    do_reset();
    w = '0; w.memreqm = 1; w.pcsrce = 1; w.rde = 5; w.memreade = 1; w.rs1d = 5;
    for (int k = 0; k < 4; k++) run_cycle(w, '{4'b0000, 3'b001, 2'b00, 2'b00}, "wait frozen");
    wr = w; wr.memreadym = 1;
    run_cycle(wr, '{4'b1111, 3'b110, 2'b00, 2'b00}, "wait release");
    check("wait stallcnt", StallCnt, 32'd4);

    // Mid-wait reset mid-sequence clears stall count at once.
    w = '0; w.memreqm = 1;
    model_cycle(w, "pre-reset wait");
    do_reset();

    // Timeout instance (limit 3): reset mid-wait must restart the wait count.
    rst_to = 1'b1;
    model_cycle(w, "to wait a");
    model_cycle(w, "to wait b");
    check("to buserr early", to_BusErr, 1'b0);
    rst_to = 1'b0;
    #1;
    check("to reset en", {to_EnF, to_FlushW}, 2'b00);
    rst_to = 1'b1;
    // Count reaches 3 after three wait cycles; the error is taken on the next still-waiting cycle.
    for (int k = 1; k <= 4; k++) begin
      model_cycle(w, "to wait");
      check($sformatf("to buserr after %0d", k), to_BusErr, (k == 4));
    end
    wr = w; wr.memreadym = 1;
    model_cycle(wr, "to ready");
    check("to err frozen", {to_EnF, to_EnD, to_EnE, to_EnM, to_FlushW}, 5'b00001);
    check("to err sticky", to_BusErr, 1'b1);
    rst_to = 1'b0;
    #1;
    check("to reset buserr", to_BusErr, 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      c.rs1d      = 5'($urandom_range(0, 3));
      c.rs2d      = 5'($urandom_range(0, 3));
      c.rs1e      = 5'($urandom_range(0, 3));
      c.rs2e      = 5'($urandom_range(0, 3));
      c.rde       = 5'($urandom_range(0, 3));
      c.rdm       = 5'($urandom_range(0, 3));
      c.rdw       = 5'($urandom_range(0, 3));
      c.memreade  = 1'($urandom_range(0, 1));
      c.pcsrce    = ($urandom_range(0, 3) == 0);
      c.regwritem = 1'($urandom_range(0, 1));
      c.regwritew = 1'($urandom_range(0, 1));
      c.memreqm   = 1'($urandom_range(0, 1));
      c.memreadym = 1'($urandom_range(0, 1));
      model_cycle(c, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
